// File: rtl/pc_fetch_pkg.sv
// Shared core package for the fetch stage.
// Holds the fetch FSM state encoding, the default reset fetch address and the
// jump-target helper used by the redirect logic.
package pc_fetch_pkg;

   localparam int unsigned PC_W = 30;

   // Word address fetched first after reset when the top is not overridden.
   localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 30'h0000000;

   // Fetch FSM state encoding.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   // Jump target: region bits of the jump's PC+1 concatenated with instr_index.
   function automatic logic [PC_W-1:0] jump_addr(input logic [PC_W-1:0] pc,
                                                 input logic [25:0]     idx);
      return {pc[29:26], idx};
   endfunction

endpackage

// File: rtl/pc_fetch_redirect.sv
// Redirect and adder-operand selection for the fetch stage.
// Ports:
//   pc_q          - current fetch PC (default adder operand 1)
//   branch_taken  - branch redirect pulse
//   jump          - jump redirect pulse (wins over branch_taken)
//   branch_pc     - PC+1 of the branch/jump instruction
//   branch_offset - sign-extended word offset
//   jump_target   - instr_index field of the jump
//   add_result    - sum from the shared core adder
//   add_op1/2     - operands driven to the shared core adder
//   redirect      - a branch or jump is requested this cycle
//   redirect_pc   - new fetch PC when redirect is set
module pc_fetch_redirect
   import pc_fetch_pkg::*;
(
   input  logic [29:0] pc_q,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic [29:0] branch_pc,
   input  logic [29:0] branch_offset,
   input  logic [25:0] jump_target,
   input  logic [29:0] add_result,
   output logic [29:0] add_op1,
   output logic [29:0] add_op2,
   output logic        redirect,
   output logic [29:0] redirect_pc
);

   // The adder is steered to the branch operands whenever a branch is
   // flagged; otherwise it produces the sequential pc_q + 1.
   always_comb begin
      add_op1 = pc_q;
      add_op2 = 30'd1;
      if (branch_taken) begin
         add_op1 = branch_pc;
         add_op2 = branch_offset;
      end
   end

   assign redirect    = branch_taken | jump;
   // The jump target needs no addition, so it bypasses the adder entirely.
   assign redirect_pc = jump ? jump_addr(branch_pc, jump_target) : add_result;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: issues word-address reads to instruction memory,
// buffers one instruction for decode and handles branch/jump redirects.
// The PC increment and branch-target sum use a shared adder outside this block.
// Ports:
//   i_clk, i_rst_n                 - clock, asynchronous active-low reset
//   o_add_op1/o_add_op2/i_add_result - shared adder interface
//   i_branch_taken, i_jump, i_branch_pc, i_branch_offset, i_jump_target
//                                  - redirect requests from decode
//   o_imem_req/o_imem_addr/i_imem_ack/i_imem_rdata - instruction memory read
//   o_instr_valid/o_instr/o_pc/i_decode_ready      - instruction to decode
//   o_dbg_state                    - current FSM state
//
// Handshakes: memory read is request/ack -- o_imem_req stays high with a
// stable o_imem_addr until the cycle i_imem_ack is seen, and i_imem_rdata is
// valid only in that cycle. Decode side is valid/ready -- a transfer happens on
// a rising edge where o_instr_valid & i_decode_ready; o_instr/o_pc are held
// while o_instr_valid is high and no transfer occurs.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [29:0] o_add_op1,
   output logic [29:0] o_add_op2,
   input  logic [29:0] i_add_result,
   input  logic        i_branch_taken,
   input  logic        i_jump,
   input  logic [29:0] i_branch_pc,
   input  logic [29:0] i_branch_offset,
   input  logic [25:0] i_jump_target,
   output logic        o_imem_req,
   output logic [29:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [29:0] o_pc,
   input  logic        i_decode_ready,
   output logic [1:0]  o_dbg_state
);

   logic [1:0]  state;
   logic [29:0] pc_q;
   logic [29:0] addr_q;
   logic        kill_q;
   logic        valid_q;
   logic [31:0] instr_q;
   logic [29:0] instr_pc_q;
   logic        redirect;
   logic [29:0] redirect_pc;
   logic        transfer;

   pc_fetch_redirect u_redirect (
      .pc_q          (pc_q),
      .branch_taken  (i_branch_taken),
      .jump          (i_jump),
      .branch_pc     (i_branch_pc),
      .branch_offset (i_branch_offset),
      .jump_target   (i_jump_target),
      .add_result    (i_add_result),
      .add_op1       (o_add_op1),
      .add_op2       (o_add_op2),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc)
   );

   assign transfer = valid_q & i_decode_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         kill_q     <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= 32'd0;
         instr_pc_q <= 30'd0;
      end else begin
         case (state)
            // One settling cycle after reset; redirects are ignored here.
            S_IDLE: begin
               addr_q <= pc_q;
               state  <= S_REQ;
            end
            S_REQ: begin
               if (i_imem_ack) begin
                  kill_q <= 1'b0;
                  if (redirect) begin
                     // Data returned for the old path is dropped.
                     pc_q   <= redirect_pc;
                     addr_q <= redirect_pc;
                  end else if (kill_q) begin
                     // Ack for a request overtaken by an earlier redirect.
                     addr_q <= pc_q;
                  end else begin
                     instr_q    <= i_imem_rdata;
                     instr_pc_q <= addr_q;
                     valid_q    <= 1'b1;
                     pc_q       <= i_add_result;
                     state      <= S_FULL;
                  end
               end else if (redirect) begin
                  // The address must stay stable until the ack, so the new
                  // path is parked in pc_q and the pending read is marked dead.
                  pc_q   <= redirect_pc;
                  kill_q <= 1'b1;
               end
            end
            S_FULL: begin
               if (redirect) begin
                  pc_q    <= redirect_pc;
                  addr_q  <= redirect_pc;
                  valid_q <= 1'b0;
                  state   <= S_REQ;
               end else if (transfer) begin
                  valid_q <= 1'b0;
                  addr_q  <= pc_q;
                  state   <= S_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign o_imem_req    = (state == S_REQ);
   assign o_imem_addr   = addr_q;
   assign o_instr_valid = valid_q;
   assign o_instr       = instr_q;
   assign o_pc          = instr_pc_q;
   assign o_dbg_state   = state;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 30'h0000000: word address fetched first after reset.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port o_add_op1, output, 30: operand 1 to the shared 30-bit word-address adder.
REQ-005 SHALL have port o_add_op2, output, 30: operand 2 to the adder.
REQ-006 SHALL have port i_add_result, input, 30: adder sum (combinational, same cycle).
REQ-007 SHALL have port i_branch_taken, input, 1: one-cycle redirect pulse from decode.
REQ-008 SHALL have port i_jump, input, 1: one-cycle jump pulse from decode.
REQ-009 SHALL have port i_branch_pc, input, 30: PC+1 of the branch/jump instruction.
REQ-010 SHALL have port i_branch_offset, input, 30: sign-extended word offset.
REQ-011 SHALL have port i_jump_target, input, 26: instr_index field.
REQ-012 SHALL have port o_imem_req, output, 1: instruction-memory read request.
REQ-013 SHALL have port o_imem_addr, output, 30: word address of the request.
REQ-014 SHALL have port i_imem_ack, input, 1: read completes; i_imem_rdata valid this cycle.
REQ-015 SHALL have port i_imem_rdata, input, 32: instruction word.
REQ-016 SHALL have port o_instr_valid, output, 1: buffered instruction available to decode.
REQ-017 SHALL have port o_instr, output, 32: buffered instruction.
REQ-018 SHALL have port o_pc, output, 30: word address of o_instr.
REQ-019 SHALL have port i_decode_ready, input, 1: decode accepts; transfer = o_instr_valid & i_decode_ready.

Function
REQ-020 SHALL use FSM states S_IDLE, S_REQ, S_FULL; S_IDLE lasts exactly one cycle after reset release, then S_REQ.
REQ-021 SHALL assert o_imem_req only in S_REQ, holding o_imem_addr stable from request start until i_imem_ack.
REQ-022 SHALL drive o_add_op1 = pc_q, o_add_op2 = 30'd1 by default; with i_branch_taken, op1 = i_branch_pc, op2 = i_branch_offset; sum wraps modulo 2^30.
REQ-023 SHALL compute jump target {i_branch_pc[29:26], i_jump_target} without the adder; i_jump has priority over i_branch_taken.
REQ-024 On non-killed ack in S_REQ: SHALL load o_instr = i_imem_rdata, o_pc = o_imem_addr, set o_instr_valid, pc_q <= i_add_result, go S_FULL (latency: ack cycle -> valid next cycle).
REQ-025 In S_FULL on transfer SHALL clear o_instr_valid and return to S_REQ next cycle with o_imem_addr = pc_q.
REQ-026 On redirect in S_FULL SHALL set pc_q to target, clear o_instr_valid (a same-cycle transfer still counts as consumed), go S_REQ.
REQ-027 On redirect in S_REQ without ack SHALL set pc_q to target and kill_q; the pending ack is discarded, kill_q cleared, state stays S_REQ issuing pc_q.
REQ-028 On redirect coinciding with ack SHALL discard that data and stay S_REQ with the new pc_q.
REQ-029 SHALL ignore redirects in S_IDLE, leaving pc_q at RESET_PC.

Reset
REQ-030 While i_rst_n low SHALL hold: state S_IDLE, pc_q = RESET_PC, o_imem_req 0, o_imem_addr RESET_PC, o_instr_valid 0, o_instr 0, o_pc 0, kill_q 0.
REQ-031 Reset asserted mid-request SHALL drop o_imem_req immediately; the late ack is ignored.

Structure
REQ-032 SHALL take FSM state encoding and RESET_PC default from a shared core package.
REQ-033 SHALL instantiate no adder; the existing adder module is instantiated beside it at core level.

Verification
REQ-034 Reset release, ack every request, ready=1 -> o_pc sequence 0,1,2,3; instructions in order.
REQ-035 Ready=0 for 5 cycles in S_FULL -> o_instr/o_pc held, o_imem_req 0, no pc_q advance.
REQ-036 Branch pc=30'd10, offset=-30'd4 in S_FULL -> next request addr 30'd6.
REQ-037 Jump pc=30'h3C000000, target 26'h0000123 during unacked request -> first ack discarded, next addr 30'h3C000123.
REQ-038 Branch coinciding with ack -> data dropped, o_instr_valid stays 0, new addr issued.
REQ-039 i_rst_n low mid-request -> o_imem_req 0 asynchronously; restart from RESET_PC.
